// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one async_fifo write port among n_req producers.
// Latency: first gnt/w_en one cycle after req rises; one IDLE arbitration cycle between bursts.
// Backpressure: full stalls the owner's burst (w_en/gnt low); optional FIFO_ARB_STATS_EN adds stall_cnt.
module fifo_wr_arbiter #(
  parameter int width     = 8,
  parameter int n_req     = 4,
  parameter int max_burst = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_req-1:0]         req,
  input  logic [n_req-1:0]         req_last,
  input  logic [n_req*width-1:0]   req_data,
  input  logic                     full,
  output logic                     w_en,
  output logic [width-1:0]         wdata,
  output logic [n_req-1:0]         gnt,
  output logic [$clog2(n_req)-1:0] owner,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int OW = $clog2(n_req);
  localparam int BW = $clog2(max_burst + 1);
  localparam logic [OW-1:0]    LAST_IDX  = OW'(n_req - 1);
  localparam logic [BW-1:0]    BURST_MAX = BW'(max_burst);
  localparam logic [n_req-1:0] GNT_ONE   = n_req'(1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  logic [OW-1:0] cand;
  int            scan;
  logic [OW-1:0] owner_inc;
  logic [BW-1:0] beat_inc;
  logic          own_req;
  logic          own_last;
  logic          acc;

  // Round-robin pick: first active requester at or above rr_ptr, wrapping n_req-1 -> 0.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    cand     = '0;
    for (int k = 0; k < n_req; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= n_req) scan = scan - n_req;
      cand = OW'(scan);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign own_req   = req[owner_q];
  assign own_last  = req_last[owner_q];
  assign acc       = (state_q == XFER) && own_req && !full;
  assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
  assign beat_inc  = beat_cnt_q + BW'(1);

  // FIFO-side outputs are combinational so a full-flag rise blocks the write in the same cycle.
  assign w_en  = acc;
  assign gnt   = acc ? (GNT_ONE << owner_q) : '0;
  assign wdata = req_data[int'(owner_q)*width +: width];
  assign owner = owner_q;
  assign busy  = (state_q == XFER);

  // Next-state: arbitrate in IDLE, count beats and close/abandon bursts in XFER.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (!own_req) begin
          // Owner withdrew: give up the port without writing.
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end else if (acc) begin
          beat_cnt_d = beat_inc;
          if (own_last || (beat_inc == BURST_MAX)) begin
            state_d  = IDLE;
            rr_ptr_d = owner_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where the owner had a word ready but the FIFO was full; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == XFER) && own_req && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Producers are modelled as word queues; each cycle the model predicts w_en/gnt/wdata/busy/owner.
// Written words are collected and compared with the model's expected FIFO contents at the end.
module tb_fifo_wr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic           full;
  logic           w_en;
  logic [W-1:0]   wdata;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    stall_cnt;
`endif

  fifo_wr_arbiter #(.width(W), .n_req(N), .max_burst(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .full     (full),
    .w_en     (w_en),
    .wdata    (wdata),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } word_t;

  word_t      pq [N][$];
  bit         drop [N];
  bit         full_r;
  int         acc_cnt [N];
  logic [7:0] fifo_exp [$];
  logic [7:0] fifo_got [$];
  int         wr_owner [$];
  bit         last_wen;

  // Reference model: -1 means no burst in progress.
  int m_owner = -1;
  int m_rr    = 0;
  int m_oreg  = 0;
  int m_beats = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        req[i]             = !drop[i];
        req_last[i]        = pq[i][0].l;
        req_data[i*W +: W] = pq[i][0].d;
      end else begin
        req[i]             = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*W +: W] = 8'($urandom);
      end
    end
    full = full_r;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_oreg  = 0;
    m_beats = 0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base, input bit last_at_end);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.d = base + 8'(k);
      w.l = last_at_end && (k == n - 1);
      pq[i].push_back(w);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      drop[i] = 1'b0;
    end
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle();
    int  pick;
    int  c;
    int  o;
    bit  acc;
    int  pop;
    drive();
    #4;
    pop  = -1;
    pick = -1;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (pick < 0 && req[c]) pick = c;
      end
      check_val("idle_busy", 32'(busy), 0);
      check_val("idle_wen", 32'(w_en), 0);
      check_val("idle_gnt", 32'(gnt), 0);
      check_val("idle_owner", 32'(owner), m_oreg);
      if (pick >= 0) begin
        m_owner = pick;
        m_oreg  = pick;
        m_beats = 0;
      end
    end else begin
      o   = m_owner;
      acc = req[o] && !full;
      check_val("xfer_busy", 32'(busy), 1);
      check_val("xfer_owner", 32'(owner), o);
      check_val("xfer_wen", 32'(w_en), 32'(acc));
      check_val("xfer_gnt", 32'(gnt), acc ? (1 << o) : 0);
      if (acc) begin
        check_val("xfer_wdata", 32'(wdata), 32'(pq[o][0].d));
        fifo_exp.push_back(pq[o][0].d);
        pop = o;
        acc_cnt[o]++;
        m_beats++;
        if (pq[o][0].l || m_beats == MB) begin
          m_owner = -1;
          m_rr    = (o + 1) % N;
        end
      end else if (!req[o]) begin
        m_owner = -1;
        m_rr    = (o + 1) % N;
      end
    end
    last_wen = w_en;
    if (w_en) begin
      fifo_got.push_back(wdata);
      wr_owner.push_back(int'(owner));
    end
    @(posedge clk);
    #1;
    if (pop >= 0) void'(pq[pop].pop_front());
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    full_r = 1'b0;
    clear_queues();
    drive();
    #1;
    check_val("rst_wen", 32'(w_en), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int  b;
    bit  pending;
    b = 0;
    pending = 1'b1;
    while (pending && b < budget) begin
      cycle();
      b++;
      pending = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (pq[i].size() > 0) pending = 1'b1;
    end
    check_val("drain_timeout", 32'(pending), 0);
  endtask

  initial begin
    logic [4:0] wen_bits;
    int         sz;
    int         stall_left;
    int         low_cnt;
    int         bud;

    rst    = 1'b1;
    full_r = 1'b0;
    clear_queues();
    drive();
    #2;
    check_val("por_busy", 32'(busy), 0);
    check_val("por_wen", 32'(w_en), 0);
    check_val("por_gnt", 32'(gnt), 0);
    check_val("por_owner", 32'(owner), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Single requester: three words, last flag on the third.
    do_reset();
    load(2, 3, 8'hA1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      wen_bits[c] = last_wen;
    end
    check_val("single_wen_pattern", 32'(wen_bits), 32'h0E);
    sz = fifo_got.size();
    check_val("single_count", 32'(sz >= 3), 1);
    if (sz >= 3) begin
      for (int j = 0; j < 3; j++) check_val("single_data", 32'(fifo_got[sz-3+j]), 32'hA1 + j);
    end

    // Contention: all four requesters always valid, bursts cut by max_burst.
    do_reset();
    for (int i = 0; i < N; i++) load(i, 20, 8'(i * 32), 1'b0);
    wr_owner.delete();
    for (int c = 0; c < 25; c++) cycle();
    check_val("cont_writes", 32'(wr_owner.size()), 20);
    for (int k = 0; k < wr_owner.size() && k < 20; k++) check_val("cont_owner", 32'(wr_owner[k]), (k / 4) % 4);

    // Backpressure: full for 5 cycles after requester 1's 2nd word.
    do_reset();
    load(1, 4, 8'hB0, 1'b0);
    stall_left = 5;
    low_cnt    = 0;
    for (int c = 0; c < 12; c++) begin
      full_r = (acc_cnt[1] == 2) && (stall_left > 0);
      if (full_r) stall_left--;
      cycle();
      if (full_r && !last_wen) low_cnt++;
    end
    full_r = 1'b0;
    check_val("bp_wen_low", 32'(low_cnt), 5);
    check_val("bp_words", 32'(acc_cnt[1]), 4);
    sz = fifo_got.size();
    if (sz >= 4) begin
      for (int j = 0; j < 4; j++) check_val("bp_data", 32'(fifo_got[sz-4+j]), 32'hB0 + j);
    end
`ifdef FIFO_ARB_STATS_EN
    check_val("stall_cnt", 32'(stall_cnt), 5);
`endif

    // Abandon: requester 3 drops req after 2 words while requester 0 waits.
    do_reset();
    load(3, 4, 8'hC0, 1'b0);
    cycle();
    load(0, 4, 8'hD0, 1'b0);
    bud = 0;
    while (acc_cnt[3] < 2 && bud < 10) begin
      cycle();
      bud++;
    end
    check_val("abandon_setup", 32'(acc_cnt[3]), 2);
    drop[3] = 1'b1;
    wr_owner.delete();
    for (int c = 0; c < 8; c++) cycle();
    check_val("abandon_writes", 32'(wr_owner.size()), 4);
    for (int k = 0; k < wr_owner.size(); k++) check_val("abandon_owner", 32'(wr_owner[k]), 0);
    drop[3] = 1'b0;

    // Reset mid-burst: outputs drop at once, next grant goes to requester 0.
    do_reset();
    load(2, 8, 8'hE0, 1'b0);
    cycle();
    cycle();
    load(0, 2, 8'hF0, 1'b1);
    drive();
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_wen", 32'(w_en), 0);
    check_val("mid_rst_gnt", 32'(gnt), 0);
    check_val("mid_rst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_owner.delete();
    for (int c = 0; c < 3; c++) cycle();
    check_val("mid_rst_first", 32'(wr_owner.size() > 0 ? wr_owner[0] : -1), 0);
    drain(100);

    // Randomized traffic with random full and occasional req withdrawal.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          int n;
          word_t w;
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            w.d = 8'($urandom);
            w.l = ($urandom_range(0, 9) < 3);
            pq[i].push_back(w);
          end
        end
        drop[i] = ($urandom_range(0, 15) == 0);
      end
      full_r = ($urandom_range(0, 3) == 0);
      cycle();
    end
    for (int i = 0; i < N; i++) drop[i] = 1'b0;
    full_r = 1'b0;
    drain(500);

    check_val("fifo_size", 32'(fifo_got.size()), 32'(fifo_exp.size()));
    for (int k = 0; k < fifo_got.size() && k < fifo_exp.size(); k++) begin
      if (fifo_got[k] !== fifo_exp[k]) check_val("fifo_word", 32'(fifo_got[k]), 32'(fifo_exp[k]));
    end
    check_val("fifo_last", 32'(fifo_got.size() > 0 ? fifo_got[$] : 0),
              32'(fifo_exp.size() > 0 ? fifo_exp[$] : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
